// File: rtl/ram_responder.sv
// ram_responder: 2^ADDR_WIDTH x DATA_WIDTH single-port RAM behind a select/write handshake, one-cycle ack.
// Define RAM_INIT_EN to include the post-reset fill engine that loads mem[a] = (2*a) mod 2^DATA_WIDTH.
module ram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  select,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ack,
  output logic                  ready,
  output logic                  init_done
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef RAM_INIT_EN
  typedef enum logic [0:0] {INIT, SERVE} state_t;
  localparam state_t RESET_STATE = INIT;
  localparam logic   RESET_READY = 1'b0;
  // One extra counter bit keeps the terminal index comparison free of wrap-around.
  localparam logic [ADDR_WIDTH:0] LAST_INDEX = {1'b0, {ADDR_WIDTH{1'b1}}};
  logic [ADDR_WIDTH:0] ic;
`else
  typedef enum logic [0:0] {SERVE} state_t;
  localparam state_t RESET_STATE = SERVE;
  localparam logic   RESET_READY = 1'b1;
`endif

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // The fill engine owns the write port while initialising; otherwise the bus does.
  always_comb begin
    mem_we    = select && write && ready;
    mem_addr  = address;
    mem_wdata = data_in;
`ifdef RAM_INIT_EN
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = ic[ADDR_WIDTH-1:0];
      mem_wdata = DATA_WIDTH'({ic, 1'b0});
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      data_out  <= '0;
      ack       <= 1'b0;
      ready     <= RESET_READY;
      init_done <= RESET_READY;
`ifdef RAM_INIT_EN
      ic        <= '0;
`endif
    end else begin
      ack <= 1'b0;
      case (state)
`ifdef RAM_INIT_EN
        INIT: begin
          ic <= ic + 1'b1;
          if (ic == LAST_INDEX) begin
            state     <= SERVE;
            ready     <= 1'b1;
            init_done <= 1'b1;
          end
        end
`endif
        SERVE: begin
          if (select && ready) begin
            ack <= 1'b1;
            if (!write) begin
              data_out <= mem[address];
            end
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: randomized self-checking bench for ram_responder against an array model of the memory.
// Build-specific sections follow RAM_INIT_EN so the bench matches whichever DUT build it is compiled with.
module tb_ram_responder;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          select   = 1'b0;
  logic          write    = 1'b0;
  logic [AW-1:0] address  = '0;
  logic [DW-1:0] data_in  = '0;
  logic [DW-1:0] data_out;
  logic          ack;
  logic          ready;
  logic          init_done;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_dout = '0;
  int            written_q[$];
  int            cycles;
  int            acks;
  int            pat_addr[6] = '{0, 1, 127, 128, 1023, 5};

  ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .select    (select),
    .write     (write),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .ack       (ack),
    .ready     (ready),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The fill leaves every word holding twice its address, modulo 256.
  task automatic fill_model();
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = DW'((2 * a) % 256);
    end
  endtask

  // Drives one request for a single edge, then checks the registered response.
  task automatic apply_stimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    select  = 1'b1;
    write   = w;
    address = a;
    data_in = d;
    @(posedge clk); #1;
    if (w) begin
      model[a] = d;
      written_q.push_back(int'(a));
    end else begin
      exp_dout = model[a];
    end
    check_output(w ? "write_ack" : "read_ack", ack, 1);
    check_output(w ? "write_data_out_held" : "read_data_out", data_out, exp_dout);
  endtask

  task automatic go_idle();
    select = 1'b0;
    write  = 1'b0;
    @(posedge clk); #1;
    check_output("idle_ack", ack, 0);
    check_output("idle_data_out", data_out, exp_dout);
  endtask

  task automatic wait_ready(output int n, output int seen_acks);
    n = 0;
    seen_acks = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (ack === 1'b1) seen_acks++;
    end
  endtask

  function automatic logic [AW-1:0] pick_read_addr();
`ifdef RAM_INIT_EN
    return AW'($urandom_range(0, DEPTH - 1));
`else
    return AW'(written_q[$urandom_range(0, written_q.size() - 1)]);
`endif
  endfunction

  initial begin
    void'($urandom(35));
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ack", ack, 0);
    check_output("reset_data_out", data_out, 0);

`ifdef RAM_INIT_EN
    check_output("reset_ready", ready, 0);
    check_output("reset_init_done", init_done, 0);
    select  = 1'b1;
    write   = 1'b1;
    address = 10'd5;
    data_in = 8'hAA;
    rst_n   = 1'b1;
    wait_ready(cycles, acks);
    select  = 1'b0;
    write   = 1'b0;
    check_output("init_cycles", cycles, 1024);
    check_output("init_acks", acks, 0);
    check_output("init_done_after_fill", init_done, 1);
    fill_model();
    foreach (pat_addr[i]) apply_stimulus(1'b0, AW'(pat_addr[i]), '0);
    check_output("addr5_untouched", data_out, 10);
`else
    check_output("reset_ready", ready, 1);
    check_output("reset_init_done", init_done, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_release_ready", ready, 1);
    check_output("post_release_init_done", init_done, 1);
    apply_stimulus(1'b1, 10'd0, 8'h11);
    apply_stimulus(1'b0, 10'd0, '0);
    check_output("addr0_readback", data_out, 8'h11);
`endif
    go_idle();

    // Write immediately followed by a read of the same address.
    apply_stimulus(1'b1, 10'd300, 8'h5C);
    apply_stimulus(1'b0, 10'd300, '0);
    check_output("rd_after_wr", data_out, 8'h5C);
    go_idle();

    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus(1'b1, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      end else begin
        apply_stimulus(1'b0, pick_read_addr(), DW'($urandom));
      end
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, pick_read_addr(), '0);
    go_idle();

    // Reset while serving: outputs must clear without waiting for a clock edge.
    apply_stimulus(1'b1, 10'd77, 8'hA5);
    apply_stimulus(1'b0, 10'd77, '0);
    select = 1'b0;
    rst_n  = 1'b0;
    #1;
    exp_dout = '0;
    check_output("async_rst_ack", ack, 0);
    check_output("async_rst_data_out", data_out, 0);
`ifdef RAM_INIT_EN
    check_output("async_rst_ready", ready, 0);
    check_output("async_rst_init_done", init_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check_output("mid_init_ready", ready, 0);
    rst_n = 1'b0;
    #1;
    check_output("mid_init_rst_ready", ready, 0);
    check_output("mid_init_rst_init_done", init_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(cycles, acks);
    check_output("refill_cycles", cycles, 1024);
    fill_model();
    apply_stimulus(1'b0, 10'd900, '0);
    check_output("addr900_after_refill", data_out, 8);
`else
    check_output("async_rst_ready", ready, 1);
    check_output("async_rst_init_done", init_done, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(1'b0, 10'd77, '0);
    check_output("mem_kept_over_reset", data_out, 8'hA5);
`endif
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Synchronous single-port 1024×8 RAM that serves read and write requests over a select/write handshake with a one-cycle response.

- Sits on the memory side of the bus, opposite the request generators and benches that drive `address`/`data_in`/`write`/`select`.
- After reset, an optional built-in init engine fills every location with the pattern (2·addr) mod 256. Requests are accepted only after the fill completes.

## Interface

Parameters:
- `ADDR_WIDTH`, 10, address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8, word width.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset; asynchronous assert, active-low.
- `select`  input  1  request strobe; sampled only while `ready`=1.
- `write`  input  1  1 = write request, 0 = read request; qualified by `select`.
- `address`  input  ADDR_WIDTH  request address.
- `data_in`  input  DATA_WIDTH  write data.
- `data_out`  output  DATA_WIDTH  read data; valid while `ack`=1 for a read.
- `ack`  output  1  one-cycle pulse acknowledging an accepted request.
- `ready`  output  1  1 = the block accepts a request this cycle.
- `init_done`  output  1  1 = init fill complete (tied 1 when the init engine is compiled out).

## Operation

- States:
  - INIT: sequential fill. Entered from reset when `RAM_INIT_EN` is defined.
  - SERVE: request handling.
- INIT:
  - An internal counter `ic` starts at 0 and writes mem[ic] = (2·ic) mod 2^DATA_WIDTH, one word per cycle.
  - After writing ic = 2^ADDR_WIDTH − 1, the FSM moves to SERVE and `ic` is not used again.
  - `ready`=0 and `init_done`=0 throughout INIT.
  - `select` is ignored: no ack and no memory change.
- SERVE:
  - A request is accepted on any rising edge where `select`=1 and `ready`=1.
  - Write: mem[address] ← data_in at that edge. `ack`=1 in the next cycle; `data_out` holds its previous value.
  - Read: `data_out` ← mem[address] and `ack`=1, both in the next cycle.
  - `ready` stays 1, so back-to-back requests are accepted every cycle. No stall state exists.
- One operation per cycle; `write` selects read or write, so read and write never conflict.
- Read of an address written in the preceding cycle returns the new data (write completes at the earlier edge).
- Reset while in INIT or SERVE:
  - Outputs return to their reset values immediately.
  - INIT restarts from address 0; a fill is never resumed part-way.
  - Memory contents are not cleared by reset.
- Arithmetic: the init pattern is (ic << 1) truncated to DATA_WIDTH. The counter is ADDR_WIDTH+1 bits wide so the terminal index is detected without wrap.

## Timing

- Reset values:
  - `data_out`=0, `ack`=0.
  - With `RAM_INIT_EN`: `ready`=0, `init_done`=0.
  - Without `RAM_INIT_EN`: `ready`=1, `init_done`=1.
- Init duration: 2^ADDR_WIDTH cycles (1024 at the defaults) after `rst_n` deasserts.
- `ready` and `init_done` rise together on the edge that leaves INIT.
- Request-to-ack latency: exactly 1 cycle for reads and writes.
- All outputs are registered.

## Configuration

- `RAM_INIT_EN` defined:
  - INIT state and fill counter are present.
  - Memory is guaranteed to hold (2·addr) mod 256 before the first request.
- `RAM_INIT_EN` undefined:
  - No INIT state and no counter; the FSM resets directly into SERVE.
  - Memory content before the first write is undefined (X in simulation).

## Test plan

- Init fill (`RAM_INIT_EN`): release reset, count cycles until `ready`=1. Required: 1024 cycles; reads of addr 0, 1, 127, 128, 1023 return 0, 2, 254, 0, 254.
- Requests during init: hold `select`=1, `write`=1, addr 5, data 0xAA throughout INIT. Required: no `ack`; read of addr 5 after init returns 10.
- Write then read back-to-back: write 0x5C to addr 300 in cycle n, read addr 300 in cycle n+1. Required: `ack` in cycles n+1 and n+2; `data_out`=0x5C in cycle n+2.
- Streaming: 20 consecutive reads at random addresses (seed 35), `select` held high. Required: 20 consecutive `ack` pulses, each `data_out` matching the model.
- Reset mid-init: assert `rst_n`=0 at fill index 600, release. Required: `ready` drops asynchronously; a full 1024-cycle fill repeats; addr 900 reads 8.
- Compiled out (no `RAM_INIT_EN`): check state after reset, then write addr 0 = 0x11 and read it back. Required: `ready`=1 and `init_done`=1 one cycle after reset release; read returns 0x11.
